// File: rtl/i2c_slave_eeprom.sv
`timescale 1ns / 1ps
// I2C target emulating a 24Cxx-style serial EEPROM. Internal byte array, one- or two-byte
// word addressing, sequential write/read, current and random read. Accepted writes are
// echoed on wr_en/wr_addr/wr_data.
module i2c_slave_eeprom #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b101_0000,
  parameter bit          BIT_CTRL   = 1'b1,
  parameter int unsigned MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  output logic              busy,
  output logic              wr_en,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [3:0] {
    StIdle, StDev, StAckDev, StAddrH, StAckH, StAddrL, StAckL,
    StWdata, StAckW, StRdata, StRack, StWaitStop
  } state_e;

  localparam logic [MEM_AW-1:0] PtrOne = MEM_AW'(1);

  state_e            state_q, state_d;
  logic [2:0]        scl_s, sda_s;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we;
  logic [7:0]        mem [2**MEM_AW];
  logic [7:0]        mem_rd;
  logic [7:0]        rx_byte;
  logic              scl_rise, scl_fall, start_det, stop_det, byte_done;

  // Open-drain: only ever pull low.
  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // [0],[1] synchronise, [2] is history; idle bus level is high.
  assign scl_rise  = scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] & scl_s[2];
  assign start_det = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
  assign stop_det  = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
  assign rx_byte   = {shift_q[6:0], sda_s[1]};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign mem_rd    = mem[ptr_q];

  // Bus synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda};
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= rx_byte;
  end

  // Protocol state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      phase_q   <= 2'd0;
      shift_q   <= 8'd0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state: START/STOP override everything; ACK states use phase 0 (drive) / 1 (release).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (start_det) begin
      state_d   = StDev;
      bit_cnt_d = 3'd0;
      phase_d   = 2'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      phase_d   = 2'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StDev, StAddrH, StAddrL, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            phase_d = 2'd0;
            if (state_q == StDev) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = StAckDev;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = StWaitStop;
              end
            end else if (state_q == StAddrH) begin
              ptr_d   = MEM_AW'({ptr_q, rx_byte});
              state_d = StAckH;
            end else if (state_q == StAddrL) begin
              ptr_d   = BIT_CTRL ? MEM_AW'({ptr_q, rx_byte}) : MEM_AW'(rx_byte);
              state_d = StAckL;
            end else begin
              mem_we    = 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_q + PtrOne;
              state_d   = StAckW;
            end
          end
        end
        StAckDev, StAckH, StAckL, StAckW: begin
          if (scl_fall) begin
            if (phase_q == 2'd0) begin
              sda_oe_d = 1'b1;
              phase_d  = 2'd1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 2'd0;
              if (state_q == StAckDev && rw_q) begin
                shift_d  = mem_rd;
                sda_oe_d = ~mem_rd[7];
                state_d  = StRdata;
              end else if (state_q == StAckDev) begin
                state_d = BIT_CTRL ? StAddrH : StAddrL;
              end else if (state_q == StAckH) begin
                state_d = StAddrL;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          // Bit 7 was driven at load; later falls present the bit after the ones clocked out.
          if (scl_fall) sda_oe_d = ~shift_q[3'd7 - bit_cnt_q];
          if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            ptr_d   = ptr_q + PtrOne;
            phase_d = 2'd0;
            state_d = StRack;
          end
        end
        StRack: begin
          if (scl_fall && phase_q == 2'd0) begin
            sda_oe_d = 1'b0;
            phase_d  = 2'd1;
          end else if (scl_rise && phase_q == 2'd1) begin
            if (sda_s[1]) begin
              state_d = StWaitStop;
              phase_d = 2'd0;
            end else begin
              phase_d = 2'd2;
            end
          end else if (scl_fall && phase_q == 2'd2) begin
            shift_d  = mem_rd;
            sda_oe_d = ~mem_rd[7];
            phase_d  = 2'd0;
            state_d  = StRdata;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule
